// File: rtl/sd_sector_loader_pkg.sv
// Shared types and widths for the SD sector loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sd_sector_loader_pkg;

  localparam int SEC_ADDR_W = 32;
  localparam int WORD_CNT_W = 9;
  localparam int SEC_CNT_W  = 16;

  // Explicit encodings keep state values stable across tools and in waveforms.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_INIT = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_READING   = 3'd4,
    S_GAP       = 3'd5,
    S_FINISH    = 3'd6,
    S_ERROR     = 3'd7
  } state_e;

  typedef logic [WORD_CNT_W-1:0] word_cnt_t;
  typedef logic [SEC_ADDR_W-1:0] sec_addr_t;
  typedef logic [SEC_CNT_W-1:0]  sec_cnt_t;

  // Word counter increment that sticks at all-ones, so a runaway sector
  // cannot wrap back to a value that looks like a correct count.
  function automatic word_cnt_t word_sat_inc(input word_cnt_t w);
    return (&w) ? w : w + word_cnt_t'(1);
  endfunction

endpackage

// File: rtl/sd_sector_loader_if.sv
// Control/status bundle between the sector loader, its host and the SD read block.
// Latency: n/a (wires only).
// Backpressure: none; the SD block paces the loader through rd_busy.
interface sd_sector_loader_if;
  import sd_sector_loader_pkg::*;

  // host side
  logic      load_start;
  sec_addr_t base_sec_addr;
  sec_cnt_t  sec_count;
  logic      load_busy;
  logic      load_done;
  logic      load_err;
  sec_cnt_t  sec_done;

  // SD read block side
  logic      sd_init_done;
  logic      rd_busy;
  logic      rd_val_en;
  logic      rd_start_en;
  sec_addr_t rd_sec_addr;

  // master: the loader itself
  modport master (
    input  load_start, base_sec_addr, sec_count, sd_init_done, rd_busy, rd_val_en,
    output rd_start_en, rd_sec_addr, load_busy, load_done, load_err, sec_done
  );

  // slave: host plus SD read block as seen by the loader
  modport slave (
    output load_start, base_sec_addr, sec_count, sd_init_done, rd_busy, rd_val_en,
    input  rd_start_en, rd_sec_addr, load_busy, load_done, load_err, sec_done
  );

endinterface

// File: rtl/sd_sector_loader.sv
// Sequences reads of consecutive SD sectors from a base address, checking words per sector.
// Latency: accepted load_start -> rd_start_en 2 cycles later when SD init is already done.
// Backpressure: waits on sd_init_done and rd_busy; load_start ignored while a run is active.
module sd_sector_loader
  import sd_sector_loader_pkg::*;
#(
  parameter int WORDS_PER_SEC = 256,
  parameter int START_TIMEOUT = 1024,  // must be >= 2
  parameter int GAP_CYCLES    = 8      // must be >= 1
) (
  input  logic                   clk_ref,
  input  logic                   rst,
  sd_sector_loader_if.master     bus
);

  // One down-counter serves both the start timeout and the inter-sector gap.
  localparam int TMR_MAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  // Timer loaded in ISSUE and examined from the next cycle on: reaching zero
  // after START_TIMEOUT-1 WAIT_BUSY cycles puts ERROR START_TIMEOUT cycles
  // after the start pulse, so the registered load_err lands one cycle later.
  localparam logic [TMR_W-1:0] TMO_LOAD  = TMR_W'(START_TIMEOUT - 2);
  // Loaded on the rd_busy fall; GAP then lasts exactly GAP_CYCLES cycles.
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
  localparam word_cnt_t        WORDS_EXP = word_cnt_t'(WORDS_PER_SEC);

  state_e           state_q, state_d;
  sec_addr_t        base_q, base_d;
  sec_cnt_t         count_q, count_d;
  sec_cnt_t         sec_done_q, sec_done_d;
  word_cnt_t        word_q, word_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             busy_prev_q, busy_prev_d;
  logic             load_busy_q, load_busy_d;
  logic             load_done_q, load_done_d;
  logic             load_err_q, load_err_d;

  word_cnt_t        words_now;
  logic             busy_fall;
  logic             words_ok;
  logic             last_sec;
  logic             tmr_zero;

  // A word arriving in the same cycle rd_busy falls still belongs to the sector.
  assign words_now = bus.rd_val_en ? word_sat_inc(word_q) : word_q;
  assign busy_fall = busy_prev_q & ~bus.rd_busy;
  assign words_ok  = (words_now == WORDS_EXP);
  assign last_sec  = ((sec_done_q + sec_cnt_t'(1)) == count_q);
  assign tmr_zero  = (tmr_q == '0);

  // State register
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.load_start) begin
          state_d = (bus.sec_count == '0) ? S_FINISH : S_WAIT_INIT;
        end
      end
      S_WAIT_INIT: begin
        if (bus.sd_init_done) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (bus.rd_busy)   state_d = S_READING;
        else if (tmr_zero) state_d = S_ERROR;
      end
      S_READING: begin
        if (busy_fall) begin
          if (!words_ok)     state_d = S_ERROR;
          else if (last_sec) state_d = S_FINISH;
          else               state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (tmr_zero) state_d = S_ISSUE;
      end
      S_FINISH: state_d = S_IDLE;
      S_ERROR:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: run parameters, sector/word counters, shared timer, status flags
  always_comb begin
    base_d      = base_q;
    count_d     = count_q;
    sec_done_d  = sec_done_q;
    word_d      = word_q;
    tmr_d       = tmr_q;
    busy_prev_d = bus.rd_busy;
    load_busy_d = load_busy_q;
    load_done_d = (state_q == S_FINISH);
    load_err_d  = (state_q == S_ERROR);
    case (state_q)
      S_IDLE: begin
        if (bus.load_start) begin
          base_d      = bus.base_sec_addr;
          count_d     = bus.sec_count;
          sec_done_d  = '0;
          load_busy_d = 1'b1;
        end
      end
      S_ISSUE: begin
        word_d = '0;
        tmr_d  = TMO_LOAD;
      end
      S_WAIT_BUSY, S_GAP: begin
        if (!tmr_zero) tmr_d = tmr_q - TMR_W'(1);
      end
      S_READING: begin
        word_d = words_now;
        if (busy_fall) begin
          tmr_d = GAP_LOAD;
          if (words_ok) sec_done_d = sec_done_q + sec_cnt_t'(1);
        end
      end
      S_FINISH, S_ERROR: begin
        load_busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      base_q      <= '0;
      count_q     <= '0;
      sec_done_q  <= '0;
      word_q      <= '0;
      tmr_q       <= '0;
      busy_prev_q <= 1'b0;
      load_busy_q <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      base_q      <= base_d;
      count_q     <= count_d;
      sec_done_q  <= sec_done_d;
      word_q      <= word_d;
      tmr_q       <= tmr_d;
      busy_prev_q <= busy_prev_d;
      load_busy_q <= load_busy_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  // Outputs: start pulse decoded from state; the address only moves when a sector completes
  always_comb begin
    bus.rd_start_en = (state_q == S_ISSUE);
    bus.rd_sec_addr = base_q + sec_addr_t'(sec_done_q);
    bus.load_busy   = load_busy_q;
    bus.load_done   = load_done_q;
    bus.load_err    = load_err_q;
    bus.sec_done    = sec_done_q;
  end

endmodule
